ddr4_v2_2_20_mc_pre_timer: RTL and testbench
============================================

Name: ddr4_v2_2_20_mc_pre_timer

Overview:
- Per-port precharge timing gate for the MC arbitration path. It is the closing-side counterpart of the activate timer.
- Tracks each of the 4 group ports from ACT to PRE. Enforces tRAS (ACT->PRE), tRTP (RD->PRE) and write recovery tWTP (WR->PRE).
- After each PRE it enforces tRP before the next ACT on that port.
- Produces qualified precharge requests (preReqT) and per-port activate-permit bits (actRpOK) that the arbiter ANDs with actReqT.

Parameters:
tRAS, 32, ACT->PRE minimum, fabric clocks, legal range 1..255
tRTP, 4, RD->PRE minimum, fabric clocks, 1..255
tWTP, 20, WR->PRE minimum (CWL+BL/2+tWR), fabric clocks, 1..255
tRP, 12, PRE->ACT minimum, fabric clocks, 1..255
CNTW, 8, timer counter width
TCQ, 0.1, simulation clock-to-q delay applied to all register updates

Ports:
clk  in  1  controller fabric clock
rst_n  in  1  asynchronous, active-low reset
preReq  in  4  per-port precharge request from group FSMs
actWin  in  4  one-hot: ACT issued from port p this cycle
rdWin  in  4  one-hot: CAS read issued from port p this cycle
wrWin  in  4  one-hot: CAS write issued from port p this cycle
preWin  in  4  one-hot: PRE issued from port p this cycle
preReqT  out  4  qualified precharge request (combinational from registered state)
actRpOK  out  4  port may issue ACT (tRP satisfied)
portOpen  out  4  registered, 1 = port holds an open row

Behaviour:
- Reset: all counters = 0, all ports in IDLE. portOpen = 0, actRpOK = 4'hF, preReqT = 0.
- Per-port FSM with two states:
  - IDLE -> OPEN on actWin[p].
  - OPEN -> IDLE on preWin[p].
  - An ACT while OPEN, or a PRE while IDLE, leaves the state unchanged and fires an assertion.
- Per-port counters rasCnt, casCnt, rpCnt, each CNTW bits:
  - Each decrements by 1 per cycle and saturates at 0.
  - An event at cycle N loads value T-1, so the blocked window is cycles N+1..N+T-1 and the first legal cycle is N+T. T=1 never blocks.
  - actWin[p] loads rasCnt = tRAS-1.
  - rdWin[p] loads casCnt = max(casCnt_dec, tRTP-1).
  - wrWin[p] loads casCnt = max(casCnt_dec, tWTP-1).
  - A WR blocking window is never shortened by a later RD.
- preWin[p] loads rpCnt = tRP-1 and clears rasCnt and casCnt.
- Output equations:
  - preReqT[p] = preReq[p] & portOpen[p] & (rasCnt==0) & (casCnt==0).
  - actRpOK[p] = ~portOpen[p] & (rpCnt==0).
- Ports are fully independent. Simultaneous events on different ports in the same cycle are all applied.
- Assertions (simulation only):
  - actWin, rdWin, wrWin and preWin are each at most one-hot.
  - rdWin[p] and wrWin[p] never both set in the same cycle.
  - rdWin/wrWin only while portOpen[p].
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first post-reset cycle allows ACT on every port.

Decomposition:
- Shared package ddr4_v2_2_20_mc_pkg gets:
  - PORTS=4 constant
  - pre_state_t enum {IDLE, OPEN}
  - a saturating-decrement function
- Natural sub-module: ddr4_v2_2_20_mc_pre_port, one per port via generate. It holds the FSM and three counters. The top level only fans out the bit slices.

Test Plan:
- tRAS gate: actWin=4'b0001 at cycle 10, preReq[0] held high -> preReqT[0]=0 for cycles 11..41, =1 at cycle 42 (tRAS=32).
- Read recovery: ACT port1 at cycle 0, rdWin[1] at cycle 40, preReq[1] high -> preReqT[1] low through cycle 43, high at cycle 44 (tRTP=4; tRAS already met).
- WR then RD max rule: wrWin[2] at cycle 50 then rdWin[2] at cycle 52 -> preReqT[2] first high at cycle 70 (tWTP=20), not cycle 56.
- tRP gate: preWin[3] at cycle 100 -> portOpen[3]=0 from cycle 101, actRpOK[3]=0 for cycles 101..111, =1 at cycle 112 (tRP=12).
- Concurrent ports: ACT on port0 and PRE on port2 in the same cycle -> each port's counters follow its own timing, no cross-blocking.
- Async reset: drop rst_n for 3 ns mid-tRAS with no clock edge -> outputs go to reset values immediately, actRpOK=4'hF, counters zero after release.

Source files
------------

// File: rtl/ddr4_v2_2_20_mc_pkg.sv
// Shared MC definitions: port count, precharge-port state encoding and a
// saturating counter decrement used by the per-port timers.
package ddr4_v2_2_20_mc_pkg;

  localparam int PORTS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } pre_state_t;

  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_mc_pre_port.sv
// One group port: open/idle row state plus tRAS, CAS->PRE and tRP timers.
// Outputs are combinational from registered state; no internal backpressure.
module ddr4_v2_2_20_mc_pre_port
  import ddr4_v2_2_20_mc_pkg::*;
#(
  parameter int tRAS = 32,
  parameter int tRTP = 4,
  parameter int tWTP = 20,
  parameter int tRP  = 12,
  parameter int CNTW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic preReq,
  input  logic actWin,
  input  logic rdWin,
  input  logic wrWin,
  input  logic preWin,
  output logic preReqT,
  output logic actRpOK,
  output logic portOpen
);

  // An event at cycle N loads T-1, so N+T is the first cycle the count reads 0.
  localparam logic [CNTW-1:0] RAS_LD = CNTW'(tRAS - 1);
  localparam logic [CNTW-1:0] RTP_LD = CNTW'(tRTP - 1);
  localparam logic [CNTW-1:0] WTP_LD = CNTW'(tWTP - 1);
  localparam logic [CNTW-1:0] RP_LD  = CNTW'(tRP - 1);

  pre_state_t      state, state_nxt;
  logic [CNTW-1:0] ras_cnt, cas_cnt, rp_cnt;
  logic [CNTW-1:0] ras_nxt, cas_nxt, rp_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ras_cnt <= '0;
      cas_cnt <= '0;
      rp_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      ras_cnt <= ras_nxt;
      cas_cnt <= cas_nxt;
      rp_cnt  <= rp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ras_nxt   = CNTW'(sat_dec(32'(ras_cnt)));
    cas_nxt   = CNTW'(sat_dec(32'(cas_cnt)));
    rp_nxt    = CNTW'(sat_dec(32'(rp_cnt)));

    case (state)
      IDLE:    if (actWin) state_nxt = OPEN;
      OPEN:    if (preWin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (actWin) ras_nxt = RAS_LD;
    // CAS recovery only ever extends, so a pending write window survives a later read.
    if (rdWin && (RTP_LD > cas_nxt)) cas_nxt = RTP_LD;
    if (wrWin && (WTP_LD > cas_nxt)) cas_nxt = WTP_LD;

    if (preWin) begin
      rp_nxt  = RP_LD;
      ras_nxt = '0;
      cas_nxt = '0;
    end
  end

  assign portOpen = (state == OPEN);
  assign preReqT  = preReq & portOpen & (ras_cnt == '0) & (cas_cnt == '0);
  assign actRpOK  = ~portOpen & (rp_cnt == '0);

  a_act_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(actWin && state == OPEN));
  a_pre_open: assert property (@(posedge clk) disable iff (!rst_n)
    !(preWin && state == IDLE));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(rdWin && wrWin));
  a_cas_open: assert property (@(posedge clk) disable iff (!rst_n)
    !((rdWin || wrWin) && state != OPEN));

endmodule

// File: rtl/ddr4_v2_2_20_mc_pre_timer.sv
// Precharge/activate timing gate for all group ports; qualifies preReq and permits ACT.
// Combinational outputs from registered per-port state; ports never block each other.
module ddr4_v2_2_20_mc_pre_timer
  import ddr4_v2_2_20_mc_pkg::*;
#(
  parameter int tRAS = 32,
  parameter int tRTP = 4,
  parameter int tWTP = 20,
  parameter int tRP  = 12,
  parameter int CNTW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] preReq,
  input  logic [PORTS-1:0] actWin,
  input  logic [PORTS-1:0] rdWin,
  input  logic [PORTS-1:0] wrWin,
  input  logic [PORTS-1:0] preWin,
  output logic [PORTS-1:0] preReqT,
  output logic [PORTS-1:0] actRpOK,
  output logic [PORTS-1:0] portOpen
);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    ddr4_v2_2_20_mc_pre_port #(
      .tRAS(tRAS),
      .tRTP(tRTP),
      .tWTP(tWTP),
      .tRP (tRP),
      .CNTW(CNTW)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .preReq  (preReq[p]),
      .actWin  (actWin[p]),
      .rdWin   (rdWin[p]),
      .wrWin   (wrWin[p]),
      .preWin  (preWin[p]),
      .preReqT (preReqT[p]),
      .actRpOK (actRpOK[p]),
      .portOpen(portOpen[p])
    );
  end

  // The arbiter grants at most one command of each kind per cycle.
  a_act_1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(actWin));
  a_rd_1h:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rdWin));
  a_wr_1h:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wrWin));
  a_pre_1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(preWin));

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_pre_timer.sv
// Bench for the precharge timer: event-table stimulus, time-based reference model
// feeding a scoreboard queue, plus hand-derived spot expectations.
module tb_ddr4_v2_2_20_mc_pre_timer;

  localparam int T_RAS    = 32;
  localparam int T_RTP    = 4;
  localparam int T_WTP    = 20;
  localparam int T_RP     = 12;
  localparam int RST_CYC  = 150;
  localparam int LAST_CYC = 190;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] preReq = '0, actWin = '0, rdWin = '0, wrWin = '0, preWin = '0;
  logic [3:0] preReqT, actRpOK, portOpen;

  always #5 clk = ~clk;

  ddr4_v2_2_20_mc_pre_timer #(
    .tRAS(T_RAS), .tRTP(T_RTP), .tWTP(T_WTP), .tRP(T_RP), .CNTW(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .preReq  (preReq),
    .actWin  (actWin),
    .rdWin   (rdWin),
    .wrWin   (wrWin),
    .preWin  (preWin),
    .preReqT (preReqT),
    .actRpOK (actRpOK),
    .portOpen(portOpen)
  );

  typedef struct {
    int         cyc;
    logic [3:0] act, rd, wr, pre, preq;
  } stim_t;

  // sig: 0 = preReqT, 1 = actRpOK, 2 = portOpen
  typedef struct {
    int   cyc;
    int   port;
    int   sig;
    logic val;
  } spot_t;

  typedef struct {
    int         cyc;
    logic [3:0] prt, aok, opn;
  } exp_t;

  stim_t stim[$];
  spot_t spot[$];
  exp_t  sb[$];

  int ras_rdy[4], cas_rdy[4], rp_rdy[4];
  bit open_m[4];
  int errors = 0;
  int checks = 0;

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      ras_rdy[p] = 0; cas_rdy[p] = 0; rp_rdy[p] = 0; open_m[p] = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] preq_cur;
    logic [3:0] a, r, w, pr;
    exp_t e, g;

    // event table: cycle, act, rd, wr, pre, preReq (preReq persists)
    stim.push_back('{0,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{10,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{20,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{40,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{50,  4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1111});
    stim.push_back('{52,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{60,  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{65,  4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b1111});
    stim.push_back('{80,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010});
    stim.push_back('{84,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1111});
    stim.push_back('{110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1111});
    stim.push_back('{115, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1111});
    stim.push_back('{130, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b1111});
    stim.push_back('{145, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
    stim.push_back('{152, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1111});

    // hand-derived expectations from the timing parameters
    spot.push_back('{11,  0, 0, 1'b0});
    spot.push_back('{41,  0, 0, 1'b0});
    spot.push_back('{42,  0, 0, 1'b1});
    spot.push_back('{41,  1, 0, 1'b0});
    spot.push_back('{43,  1, 0, 1'b0});
    spot.push_back('{44,  1, 0, 1'b1});
    spot.push_back('{56,  2, 0, 1'b0});
    spot.push_back('{69,  2, 0, 1'b0});
    spot.push_back('{70,  2, 0, 1'b1});
    spot.push_back('{100, 3, 2, 1'b1});
    spot.push_back('{101, 3, 2, 1'b0});
    spot.push_back('{101, 3, 1, 1'b0});
    spot.push_back('{111, 3, 1, 1'b0});
    spot.push_back('{112, 3, 1, 1'b1});
    spot.push_back('{131, 0, 2, 1'b1});
    spot.push_back('{140, 0, 0, 1'b0});
    spot.push_back('{141, 2, 1, 1'b0});
    spot.push_back('{142, 2, 1, 1'b1});
    spot.push_back('{183, 1, 0, 1'b0});
    spot.push_back('{184, 1, 0, 1'b1});

    model_reset();
    preReq = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk4("reset preReqT", preReqT, 4'h0);
    chk4("reset actRpOK", actRpOK, 4'hF);
    chk4("reset portOpen", portOpen, 4'h0);
    rst_n = 1'b1;
    preq_cur = 4'h0;

    for (int c = 0; c <= LAST_CYC; c++) begin
      @(posedge clk);
      #1;
      a = '0; r = '0; w = '0; pr = '0;
      foreach (stim[i]) begin
        if (stim[i].cyc == c) begin
          a = stim[i].act; r = stim[i].rd; w = stim[i].wr; pr = stim[i].pre;
          preq_cur = stim[i].preq;
        end
      end
      actWin = a; rdWin = r; wrWin = w; preWin = pr; preReq = preq_cur;

      if (c == RST_CYC) begin
        rst_n = 1'b0;
        #1;
        chk4("async rst preReqT", preReqT, 4'h0);
        chk4("async rst actRpOK", actRpOK, 4'hF);
        chk4("async rst portOpen", portOpen, 4'h0);
        #2;
        rst_n = 1'b1;
        model_reset();
      end

      e.cyc = c;
      for (int p = 0; p < 4; p++) begin
        e.prt[p] = preq_cur[p] & open_m[p] & (c >= ras_rdy[p]) & (c >= cas_rdy[p]);
        e.aok[p] = !open_m[p] && (c >= rp_rdy[p]);
        e.opn[p] = open_m[p];
      end
      sb.push_back(e);

      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard c%0d: got empty queue want entry", c);
      end else begin
        g = sb.pop_front();
        chk4($sformatf("c%0d preReqT", g.cyc), preReqT, g.prt);
        chk4($sformatf("c%0d actRpOK", g.cyc), actRpOK, g.aok);
        chk4($sformatf("c%0d portOpen", g.cyc), portOpen, g.opn);
      end

      foreach (spot[i]) begin
        if (spot[i].cyc == c) begin
          logic [3:0] v;
          logic       got;
          v = (spot[i].sig == 0) ? preReqT : (spot[i].sig == 1) ? actRpOK : portOpen;
          got = v[spot[i].port];
          checks++;
          if (got !== spot[i].val) begin
            errors++;
            $display("FAIL spot c%0d port%0d sig%0d: got %b want %b",
                     c, spot[i].port, spot[i].sig, got, spot[i].val);
          end
        end
      end

      for (int p = 0; p < 4; p++) begin
        if (a[p]) begin
          open_m[p]  = 1'b1;
          ras_rdy[p] = c + T_RAS;
        end
        if (r[p] && (c + T_RTP > cas_rdy[p])) cas_rdy[p] = c + T_RTP;
        if (w[p] && (c + T_WTP > cas_rdy[p])) cas_rdy[p] = c + T_WTP;
        if (pr[p]) begin
          open_m[p]  = 1'b0;
          rp_rdy[p]  = c + T_RP;
          ras_rdy[p] = 0;
          cas_rdy[p] = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
